// File: rtl/vec_cmd_sequencer.sv
// rtl/vec_cmd_sequencer.sv - queued command sequencer in front of the vector accelerator
// Optional watchdog: define VEC_CMD_SEQUENCER_WATCHDOG_EN.
module vec_cmd_sequencer #(
  parameter int els_p     = 12,
  parameter int vlen_p    = 2,
  parameter int vdw_p     = 4,
  parameter int depth_p   = 4,
  parameter int timeout_p = 255,
  localparam int a_lp  = (els_p > 1) ? $clog2(els_p) : 1,
  localparam int dw_lp = vlen_p * vdw_p,
  localparam int cw_lp = $clog2(depth_p + 1),
  localparam int pw_lp = (depth_p > 1) ? $clog2(depth_p) : 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              cmd_v_i,
  output logic              cmd_ready_o,
  input  logic [3:0]        cmd_op_i,
  input  logic [a_lp-1:0]   cmd_addrA_i,
  input  logic [a_lp-1:0]   cmd_addrB_i,
  input  logic [a_lp-1:0]   cmd_addrD_i,
  input  logic [vdw_p-1:0]  cmd_scalar_i,
  input  logic [dw_lp-1:0]  cmd_data_i,
  output logic [3:0]        acc_op_o,
  output logic [a_lp-1:0]   acc_addrA_o,
  output logic [a_lp-1:0]   acc_addrB_o,
  output logic [a_lp-1:0]   acc_addrD_o,
  output logic [vdw_p-1:0]  acc_scalar_o,
  output logic [dw_lp-1:0]  acc_w_data_o,
  output logic              acc_v_o,
  input  logic              acc_ready_i,
  input  logic              acc_done_i,
  input  logic [dw_lp-1:0]  acc_r_data_i,
  output logic              acc_yumi_o,
  output logic              resp_v_o,
  output logic [dw_lp-1:0]  resp_data_o,
  input  logic              resp_yumi_i,
  output logic              busy_o,
  output logic [cw_lp-1:0]  count_o,
  output logic              err_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [3:0] OP_READ = 4'b1000;

  logic [3:0]       op_mem     [depth_p];
  logic [a_lp-1:0]  a_mem      [depth_p];
  logic [a_lp-1:0]  b_mem      [depth_p];
  logic [a_lp-1:0]  d_mem      [depth_p];
  logic [vdw_p-1:0] scalar_mem [depth_p];
  logic [dw_lp-1:0] data_mem   [depth_p];

  logic [pw_lp-1:0] wptr_q, rptr_q;
  logic [cw_lp-1:0] count_q;
  logic [1:0]       state_q, state_d;
  logic [3:0]       op_lat_q;
  logic [dw_lp-1:0] resp_data_q;
  logic             err_q;

  logic push, pop, issue, drop, head_valid, head_illegal, lat_read, timeout;

  assign head_valid   = (count_q != '0);
  assign head_illegal = (acc_op_o >= 4'b1010) && (acc_op_o <= 4'b1110);
  assign cmd_ready_o  = (count_q < cw_lp'(depth_p));
  assign push         = cmd_v_i && cmd_ready_o;

  assign acc_op_o     = op_mem[rptr_q];
  assign acc_addrA_o  = a_mem[rptr_q];
  assign acc_addrB_o  = b_mem[rptr_q];
  assign acc_addrD_o  = d_mem[rptr_q];
  assign acc_scalar_o = scalar_mem[rptr_q];
  assign acc_w_data_o = data_mem[rptr_q];

  // Illegal opcodes are dropped from the head without ever being offered.
  assign acc_v_o  = (state_q == IDLE) && head_valid && !head_illegal;
  assign issue    = acc_v_o && acc_ready_i;
  assign drop     = (state_q == IDLE) && head_valid && head_illegal;
  assign pop      = issue || drop;
  assign lat_read = (op_lat_q == OP_READ);

  assign acc_yumi_o  = (state_q == WAIT) && acc_done_i && lat_read;
  assign resp_v_o    = (state_q == RESP);
  assign resp_data_o = resp_data_q;
  assign busy_o      = head_valid || (state_q != IDLE);
  assign count_o     = count_q;
  assign err_o       = err_q;

`ifdef VEC_CMD_SEQUENCER_WATCHDOG_EN
  localparam int ww_lp = $clog2(timeout_p + 1);
  logic [ww_lp-1:0] wd_q;

  // A done arriving on the timeout cycle takes precedence.
  assign timeout = (state_q == WAIT) && !acc_done_i && (wd_q == ww_lp'(timeout_p - 1));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)                wd_q <= '0;
    else if (issue)             wd_q <= '0;
    else if (state_q == WAIT)   wd_q <= wd_q + ww_lp'(1);
  end
`else
  logic unused_timeout;
  assign unused_timeout = (timeout_p != 0);
  assign timeout        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (issue) state_d = WAIT;
      WAIT: if (acc_done_i || timeout) state_d = lat_read ? RESP : IDLE;
      RESP: if (resp_yumi_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      op_mem[wptr_q]     <= cmd_op_i;
      a_mem[wptr_q]      <= cmd_addrA_i;
      b_mem[wptr_q]      <= cmd_addrB_i;
      d_mem[wptr_q]      <= cmd_addrD_i;
      scalar_mem[wptr_q] <= cmd_scalar_i;
      data_mem[wptr_q]   <= cmd_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + pw_lp'(1);
      if (pop)  rptr_q <= rptr_q + pw_lp'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + cw_lp'(1);
        2'b01:   count_q <= count_q - cw_lp'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      op_lat_q    <= '0;
      resp_data_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (issue) op_lat_q <= acc_op_o;
      if (acc_yumi_o)
        resp_data_q <= acc_r_data_i;
      else if (timeout && lat_read)
        resp_data_q <= '0;
      if (drop || timeout) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vec_cmd_sequencer.sv
// tb/tb_vec_cmd_sequencer.sv - directed self-checking bench for vec_cmd_sequencer
module tb_vec_cmd_sequencer;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       cmd_v_i, cmd_ready_o;
  logic [3:0] cmd_op_i, cmd_addrA_i, cmd_addrB_i, cmd_addrD_i, cmd_scalar_i;
  logic [7:0] cmd_data_i;
  logic [3:0] acc_op_o, acc_addrA_o, acc_addrB_o, acc_addrD_o, acc_scalar_o;
  logic [7:0] acc_w_data_o, acc_r_data_i, resp_data_o;
  logic       acc_v_o, acc_ready_i, acc_done_i, acc_yumi_o;
  logic       resp_v_o, resp_yumi_i, busy_o, err_o;
  logic [2:0] count_o;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vec_cmd_sequencer #(.els_p(12), .vlen_p(2), .vdw_p(4), .depth_p(4), .timeout_p(8)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .cmd_v_i(cmd_v_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
    .cmd_addrA_i(cmd_addrA_i), .cmd_addrB_i(cmd_addrB_i), .cmd_addrD_i(cmd_addrD_i),
    .cmd_scalar_i(cmd_scalar_i), .cmd_data_i(cmd_data_i),
    .acc_op_o(acc_op_o), .acc_addrA_o(acc_addrA_o), .acc_addrB_o(acc_addrB_o),
    .acc_addrD_o(acc_addrD_o), .acc_scalar_o(acc_scalar_o), .acc_w_data_o(acc_w_data_o),
    .acc_v_o(acc_v_o), .acc_ready_i(acc_ready_i), .acc_done_i(acc_done_i),
    .acc_r_data_i(acc_r_data_i), .acc_yumi_o(acc_yumi_o),
    .resp_v_o(resp_v_o), .resp_data_o(resp_data_o), .resp_yumi_i(resp_yumi_i),
    .busy_o(busy_o), .count_o(count_o), .err_o(err_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered just after a falling edge; leaves just after the falling edge following the push edge.
  task automatic push(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] d, input logic [7:0] data);
    cmd_op_i = op; cmd_addrA_i = a; cmd_addrB_i = b; cmd_addrD_i = d;
    cmd_scalar_i = 4'h3; cmd_data_i = data; cmd_v_i = 1'b1;
    @(negedge clk);
    cmd_v_i = 1'b0;
    #1;
  endtask

  // Accept the next issue, then return done two cycles after the accept edge.
  task automatic serve(input logic [3:0] exp_op, input logic [3:0] exp_d, input logic [7:0] rdat);
    int n;
    n = 0;
    acc_ready_i = 1'b1;
    #1;
    while (!acc_v_o && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("issue_v", acc_v_o, 1);
    check("issue_op", acc_op_o, exp_op);
    check("issue_addrD", acc_addrD_o, exp_d);
    @(negedge clk);
    acc_ready_i = 1'b0;
    #1;
    check("wait_no_issue", acc_v_o, 0);
    @(negedge clk);
    acc_done_i = 1'b1; acc_r_data_i = rdat;
    #1;
    check("yumi", acc_yumi_o, (exp_op == 4'b1000));
    @(negedge clk);
    acc_done_i = 1'b0;
    #1;
  endtask

  task automatic consume();
    resp_yumi_i = 1'b1;
    @(negedge clk);
    resp_yumi_i = 1'b0;
    #1;
    check("resp_v_after_yumi", resp_v_o, 0);
  endtask

  initial begin
    reset_i = 1'b1; cmd_v_i = 0; cmd_op_i = 0; cmd_addrA_i = 0; cmd_addrB_i = 0;
    cmd_addrD_i = 0; cmd_scalar_i = 0; cmd_data_i = 0; acc_ready_i = 0; acc_done_i = 0;
    acc_r_data_i = 0; resp_yumi_i = 0;
    #1;
    check("rst_count", count_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_err", err_o, 0);
    check("rst_acc_v", acc_v_o, 0);
    check("rst_yumi", acc_yumi_o, 0);
    check("rst_resp_v", resp_v_o, 0);
    check("rst_resp_data", resp_data_o, 0);
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
    #1;
    check("rst_cmd_ready", cmd_ready_o, 1);

    // write then read back through the response register
    push(4'b1001, 4'd0, 4'd0, 4'd0, 8'b0001_0001);
    check("latency_acc_v", acc_v_o, 1);
    check("latency_wdata", acc_w_data_o, 8'h11);
    check("latency_count", count_o, 1);
    check("latency_busy", busy_o, 1);
    serve(4'b1001, 4'd0, 8'h00);
    push(4'b1000, 4'd0, 4'd0, 4'd0, 8'h00);
    check("rd_addrA", acc_addrA_o, 0);
    serve(4'b1000, 4'd0, 8'b0001_0001);
    check("rd_resp_v", resp_v_o, 1);
    check("rd_resp_data", resp_data_o, 8'h11);
    repeat (3) @(negedge clk);
    #1;
    check("rd_resp_held_v", resp_v_o, 1);
    check("rd_resp_held_data", resp_data_o, 8'h11);
    consume();
    check("rd_idle_busy", busy_o, 0);

    // fill to depth, refuse the fifth until a pop, order across wrap
    push(4'b1001, 0, 0, 4'd1, 8'h01);
    push(4'b1001, 0, 0, 4'd2, 8'h02);
    push(4'b1001, 0, 0, 4'd3, 8'h03);
    push(4'b1001, 0, 0, 4'd4, 8'h04);
    check("full_count", count_o, 4);
    check("full_ready", cmd_ready_o, 0);
    cmd_op_i = 4'b1001; cmd_addrD_i = 4'd5; cmd_data_i = 8'h05; cmd_v_i = 1'b1;
    @(negedge clk); #1;
    check("full_refused", count_o, 4);
    acc_ready_i = 1'b1; #1;
    check("full_head_d", acc_addrD_o, 1);
    @(negedge clk);
    acc_ready_i = 1'b0; #1;
    check("full_no_passthru", count_o, 3);
    @(negedge clk);
    cmd_v_i = 1'b0; #1;
    check("full_fifth_in", count_o, 4);
    acc_done_i = 1'b1;
    @(negedge clk);
    acc_done_i = 1'b0; #1;
    serve(4'b1001, 4'd2, 8'h00);
    serve(4'b1001, 4'd3, 8'h00);
    serve(4'b1001, 4'd4, 8'h00);
    serve(4'b1001, 4'd5, 8'h00);
    check("full_drained", count_o, 0);

    // writes, mmul, read: read held back until mmul completes
    push(4'b1001, 0, 0, 4'd0, 8'b0001_0001);
    push(4'b1001, 0, 0, 4'd1, 8'b0010_0010);
    push(4'b1001, 0, 0, 4'd2, 8'b0001_0100);
    push(4'b1001, 0, 0, 4'd3, 8'b0011_0010);
    serve(4'b1001, 4'd0, 8'h00);
    push(4'b1111, 4'd0, 4'd2, 4'd4, 8'h00);
    serve(4'b1001, 4'd1, 8'h00);
    serve(4'b1001, 4'd2, 8'h00);
    serve(4'b1001, 4'd3, 8'h00);
    push(4'b1000, 4'd4, 4'd0, 4'd0, 8'h00);
    serve(4'b1111, 4'd4, 8'h00);
    check("seq_read_next", acc_op_o, 4'b1000);
    check("seq_read_addr", acc_addrA_o, 4);
    serve(4'b1000, 4'd0, 8'h5A);
    check("seq_resp_data", resp_data_o, 8'h5A);
    consume();

    // response not consumed: no issue while RESP
    push(4'b1000, 4'd1, 0, 4'd0, 8'h00);
    push(4'b1001, 0, 0, 4'd6, 8'h66);
    push(4'b1001, 0, 0, 4'd7, 8'h77);
    serve(4'b1000, 4'd0, 8'h22);
    acc_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      check("resp_hold_no_issue", acc_v_o, 0);
    end
    check("resp_hold_v", resp_v_o, 1);
    check("resp_hold_count", count_o, 2);
    check("resp_hold_data", resp_data_o, 8'h22);
    resp_yumi_i = 1'b1;
    @(negedge clk);
    resp_yumi_i = 1'b0; #1;
    check("resume_issue", acc_v_o, 1);
    serve(4'b1001, 4'd6, 8'h00);
    serve(4'b1001, 4'd7, 8'h00);

    // illegal opcode dropped between two writes
    push(4'b1001, 0, 0, 4'd8, 8'h88);
    push(4'b1100, 0, 0, 4'd10, 8'hAA);
    push(4'b1001, 0, 0, 4'd9, 8'h99);
    serve(4'b1001, 4'd8, 8'h00);
    check("ill_no_issue", acc_v_o, 0);
    check("ill_count_before", count_o, 2);
    check("ill_err_before", err_o, 0);
    @(negedge clk); #1;
    check("ill_err", err_o, 1);
    check("ill_count_after", count_o, 1);
    serve(4'b1001, 4'd9, 8'h00);
    check("ill_err_sticky", err_o, 1);

`ifdef VEC_CMD_SEQUENCER_WATCHDOG_EN
    push(4'b1000, 4'd3, 0, 4'd0, 8'h00);
    acc_ready_i = 1'b1; #1;
    check("wd_issue", acc_v_o, 1);
    @(negedge clk);
    acc_ready_i = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check("wd_not_yet", resp_v_o, 0);
    @(negedge clk); #1;
    check("wd_resp_v", resp_v_o, 1);
    check("wd_resp_data", resp_data_o, 0);
    check("wd_err", err_o, 1);
    consume();
`endif

    // reset while in WAIT with three commands queued
    push(4'b1001, 0, 0, 4'd1, 8'h01);
    push(4'b1001, 0, 0, 4'd2, 8'h02);
    push(4'b1001, 0, 0, 4'd3, 8'h03);
    push(4'b1001, 0, 0, 4'd4, 8'h04);
    acc_ready_i = 1'b1;
    @(negedge clk);
    acc_ready_i = 1'b0; #1;
    check("mid_count", count_o, 3);
    check("mid_busy", busy_o, 1);
    reset_i = 1'b1; #1;
    check("mid_rst_count", count_o, 0);
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_err", err_o, 0);
    check("mid_rst_acc_v", acc_v_o, 0);
    check("mid_rst_resp_v", resp_v_o, 0);
    @(negedge clk);
    reset_i = 1'b0; #1;
    check("mid_rst_ready", cmd_ready_o, 1);
    @(negedge clk); #1;
    check("mid_rst_idle", acc_v_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
